// File: rtl/rx_tx_sequencer_if.sv
// Control/status bundle between top-level link control and the RX/TX enable sequencer.
interface rx_tx_sequencer_if;
  logic       run;
  logic       link_up;
  logic       tx_idle;
  logic       rx_enable;
  logic       tx_enable;
  logic       running;
  logic       link_lost;
  logic       drain_timeout;
  logic [1:0] state;

  modport master (
    output run, link_up, tx_idle,
    input  rx_enable, tx_enable, running, link_lost, drain_timeout, state
  );

  modport slave (
    input  run, link_up, tx_idle,
    output rx_enable, tx_enable, running, link_lost, drain_timeout, state
  );
endinterface

// File: rtl/rx_tx_sequencer.sv
// Brings RX up, lets it settle, then enables TX; on shutdown stops TX, drains, then drops RX.
module rx_tx_sequencer #(
  parameter int SETTLE_CYCLES = 16,
  parameter int DRAIN_CYCLES  = 32,
  parameter int CW            = 16
) (
  input logic             clk,
  input logic             reset,
  rx_tx_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LOAD  = CW'(DRAIN_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lost_d, timeout_d;
  logic          lost_q, timeout_q;
  logic          rx_q, tx_q, running_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lost_d    = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.run && bus.link_up) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (!bus.link_up) begin
          state_d = IDLE;
          lost_d  = 1'b1;
        end else if (!bus.run) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RUN: begin
        if (!bus.link_up) begin
          state_d = IDLE;
          lost_d  = 1'b1;
        end else if (!bus.run) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        // A clean tx_idle exit wins over an expiring counter.
        if (!bus.link_up) begin
          state_d = IDLE;
          lost_d  = 1'b1;
        end else if (bus.tx_idle) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lost_q    <= 1'b0;
      timeout_q <= 1'b0;
      rx_q      <= 1'b0;
      tx_q      <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lost_q    <= lost_d;
      timeout_q <= timeout_d;
      rx_q      <= (state_d != IDLE);
      tx_q      <= (state_d == RUN);
      running_q <= (state_d == RUN);
    end
  end

  assign bus.state         = state_q;
  assign bus.rx_enable     = rx_q;
  assign bus.tx_enable     = tx_q;
  assign bus.running       = running_q;
  assign bus.link_lost     = lost_q;
  assign bus.drain_timeout = timeout_q;

endmodule

// File: tb/tb_rx_tx_sequencer.sv
// Directed test-plan scenarios followed by random traffic, checked against a phase/elapsed-time model.
module tb_rx_tx_sequencer;

  localparam int SETTLE = 4;
  localparam int DRAIN  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rx_tx_sequencer_if bus ();

  rx_tx_sequencer #(.SETTLE_CYCLES(SETTLE), .DRAIN_CYCLES(DRAIN), .CW(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: current phase (0..3) and number of whole cycles spent in it since entry.
  int m_phase   = 0;
  int m_elapsed = 0;
  bit m_lost    = 0;
  bit m_tout    = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_edge(input bit r, input bit ru, input bit lu, input bit ti);
    m_lost = 0;
    m_tout = 0;
    if (r) begin
      m_phase   = 0;
      m_elapsed = 0;
      return;
    end
    case (m_phase)
      0: if (ru && lu) begin m_phase = 1; m_elapsed = 0; end
      1: begin
        m_elapsed++;
        if (!lu)                     begin m_phase = 0; m_lost = 1; end
        else if (!ru)                m_phase = 0;
        else if (m_elapsed == SETTLE) m_phase = 2;
      end
      2: begin
        if (!lu)      begin m_phase = 0; m_lost = 1; end
        else if (!ru) begin m_phase = 3; m_elapsed = 0; end
      end
      default: begin
        m_elapsed++;
        if (!lu)                    begin m_phase = 0; m_lost = 1; end
        else if (ti)                m_phase = 0;
        else if (m_elapsed == DRAIN) begin m_phase = 0; m_tout = 1; end
      end
    endcase
  endfunction

  // Apply one cycle of inputs, advance the model, then compare all outputs away from the edge.
  task automatic step(input bit r, input bit ru, input bit lu, input bit ti);
    reset       = r;
    bus.run     = ru;
    bus.link_up = lu;
    bus.tx_idle = ti;
    @(posedge clk);
    model_edge(r, ru, lu, ti);
    #1;
    check("state",         bus.state,         8'(m_phase));
    check("rx_enable",     bus.rx_enable,     8'(m_phase != 0));
    check("tx_enable",     bus.tx_enable,     8'(m_phase == 2));
    check("running",       bus.running,       8'(m_phase == 2));
    check("link_lost",     bus.link_lost,     8'(m_lost));
    check("drain_timeout", bus.drain_timeout, 8'(m_tout));
  endtask

  int cnt_a, cnt_b;

  initial begin
    reset = 1'b1; bus.run = 1'b0; bus.link_up = 1'b0; bus.tx_idle = 1'b0;

    // Plan 1: reset, then bring-up; state 1,1,1,1 then 2.
    repeat (3) step(1, 0, 0, 0);
    check("rst_state", bus.state, 8'd0);
    check("rst_rx",    bus.rx_enable, 8'd0);
    check("rst_tx",    bus.tx_enable, 8'd0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 1, 0);
      check("p1_state", bus.state,     (i < 4) ? 8'd1 : 8'd2);
      check("p1_tx",    bus.tx_enable, (i < 4) ? 8'd0 : 8'd1);
    end

    // Plan 2: clean drain, tx_idle rises on the fourth edge after TX falls.
    step(0, 0, 1, 0);
    check("p2_tx_fall", bus.tx_enable, 8'd0);
    check("p2_rx_held", bus.rx_enable, 8'd1);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, (i == 3));
      if (bus.rx_enable)     cnt_a++;
      if (bus.drain_timeout) cnt_b++;
    end
    check("p2_rx_edges", 8'(cnt_a), 8'd3);
    check("p2_no_tout",  8'(cnt_b), 8'd0);

    // Plan 3: drain timeout.
    repeat (5) step(0, 1, 1, 0);
    check("p3_in_run", bus.state, 8'd2);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 1, 0);
      if (bus.state == 2'd3) cnt_a++;
      if (bus.drain_timeout) begin
        cnt_b++;
        check("p3_tout_state", bus.state, 8'd0);
      end
    end
    check("p3_drain_len",  8'(cnt_a), 8'd8);
    check("p3_tout_count", 8'(cnt_b), 8'd1);

    // Plan 4: link drop in SETTLE and in RUN, then restart after one IDLE cycle.
    repeat (2) step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    check("p4s_state", bus.state, 8'd0);
    check("p4s_lost",  bus.link_lost, 8'd1);
    step(0, 1, 1, 0);
    check("p4s_restart", bus.state, 8'd1);
    check("p4s_lost_1c", bus.link_lost, 8'd0);
    repeat (4) step(0, 1, 1, 0);
    check("p4r_in_run", bus.state, 8'd2);
    step(0, 1, 0, 0);
    check("p4r_rx",   bus.rx_enable, 8'd0);
    check("p4r_lost", bus.link_lost, 8'd1);
    step(0, 1, 1, 0);
    check("p4r_restart", bus.state, 8'd1);

    // Plan 5: reset mid-drain.
    repeat (4) step(0, 1, 1, 0);
    repeat (2) step(0, 0, 1, 0);
    check("p5_in_drain", bus.state, 8'd3);
    step(1, 0, 1, 0);
    check("p5_state", bus.state, 8'd0);
    check("p5_rx",    bus.rx_enable, 8'd0);
    check("p5_lost",  bus.link_lost, 8'd0);
    check("p5_tout",  bus.drain_timeout, 8'd0);

    // Plan 6: run and link_up drop together in RUN.
    repeat (5) step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    check("p6_state", bus.state, 8'd0);
    check("p6_lost",  bus.link_lost, 8'd1);
    step(0, 0, 1, 0);
    check("p6_lost_1c", bus.link_lost, 8'd0);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 29) != 0),
           ($urandom_range(0, 3) == 0));
      check("excl_pulses", 8'(bus.link_lost & bus.drain_timeout), 8'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
